// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the CPU write port and the UART transmitter.
// First-word-fall-through head, saturated occupancy count and a sticky overflow flag.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              UartClock,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Dev11_Load,
    input  logic              TFdataRead,
    input  logic              ClearTF,
    output logic [DATA_W-1:0] TxData,
    output logic              TxValid,
    output logic [ADDR_W-1:0] TFcount,
    output logic              TFfull,
    output logic              TFoverflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              wr_acc, rd_acc;

    assign TFfull  = (count_q == FULL_CNT);
    assign TxValid = (count_q != '0);

    // A pop frees the slot in the same cycle, so a full FIFO still takes a write alongside a read.
    assign wr_acc = Dev11_Load & (~TFfull | TFdataRead);
    assign rd_acc = TFdataRead & TxValid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (ClearTF) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
                default: count_d = count_q;
            endcase
            if (Dev11_Load && !wr_acc) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge UartClock) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; writes are suppressed while a reset or flush is in effect.
    always_ff @(posedge UartClock) begin
        if (Reset_n && !ClearTF && wr_acc)
            mem_q[wr_ptr_q] <= WrData;
    end

    assign TxData     = TxValid ? mem_q[rd_ptr_q] : '0;
    assign TFcount    = TFfull ? '1 : count_q[ADDR_W-1:0];
    assign TFoverflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_uart_tx_fifo;
    logic       UartClock = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] WrData = 8'h00;
    logic       Dev11_Load = 1'b0;
    logic       TFdataRead = 1'b0;
    logic       ClearTF = 1'b0;
    logic [7:0] TxData;
    logic       TxValid;
    logic [3:0] TFcount;
    logic       TFfull;
    logic       TFoverflow;

    int checks_total = 0;
    int checks_passed = 0;

    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;

    uart_tx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .UartClock (UartClock),
        .Reset_n   (Reset_n),
        .WrData    (WrData),
        .Dev11_Load(Dev11_Load),
        .TFdataRead(TFdataRead),
        .ClearTF   (ClearTF),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .TFcount   (TFcount),
        .TFfull    (TFfull),
        .TFoverflow(TFoverflow)
    );

    always #5 UartClock = ~UartClock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model of one clock edge from the rules: queue of bytes, sticky overflow bit.
    task automatic model_edge(input logic ld, input logic [7:0] d, input logic rd,
                              input logic clr, input logic rst);
        int  n;
        bit  wacc, racc;
        logic [7:0] dropped;
        n = model_q.size();
        if (!rst || clr) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            wacc = ld && (n < 16 || rd);
            racc = rd && (n > 0);
            if (ld && !wacc) model_ovf = 1'b1;
            if (racc) dropped = model_q.pop_front();
            if (wacc) model_q.push_back(d);
        end
    endtask

    task automatic compare_outputs(input string ctx);
        int n;
        logic [7:0] head;
        n = model_q.size();
        head = (n > 0) ? model_q[0] : 8'h00;
        check({ctx, ".TxValid"}, 32'(TxValid), 32'(n > 0));
        check({ctx, ".TxData"}, 32'(TxData), 32'(head));
        check({ctx, ".TFcount"}, 32'(TFcount), 32'((n > 15) ? 15 : n));
        check({ctx, ".TFfull"}, 32'(TFfull), 32'(n == 16));
        check({ctx, ".TFoverflow"}, 32'(TFoverflow), 32'(model_ovf));
    endtask

    task automatic cycle(input string ctx, input logic ld, input logic [7:0] d,
                         input logic rd, input logic clr, input logic rst);
        Dev11_Load = ld;
        WrData     = d;
        TFdataRead = rd;
        ClearTF    = clr;
        Reset_n    = rst;
        @(posedge UartClock);
        model_edge(ld, d, rd, clr, rst);
        #1;
        compare_outputs(ctx);
        $display("%0t %s ld=%0b d=%02h rd=%0b clr=%0b rst_n=%0b -> valid=%0b data=%02h cnt=%0d full=%0b ovf=%0b",
                 $time, ctx, ld, d, rd, clr, rst, TxValid, TxData, TFcount, TFfull, TFoverflow);
    endtask

    initial begin
        int written;
        int budget;
        logic ld, rd;

        // Reset must override any concurrent strobes.
        for (int i = 0; i < 3; i++)
            cycle("reset", 1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);

        cycle("wrA5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        cycle("popA5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle("popEmpty", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++)
            cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        cycle("wrFFfull", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle("clearOvf", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 16; i++)
            cycle("fill2", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
        cycle("wrRdFull55", 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        cycle("wrRdEmpty3C", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        cycle("pop3C", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // 40 bytes with random pops, at most 10 outstanding, wrapping the pointers.
        written = 0;
        budget = 0;
        while ((written < 40 || model_q.size() > 0) && budget < 600) begin
            ld = (written < 40) && (model_q.size() < 10) && ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 2) != 0);
            cycle("stream", ld, 8'($urandom), rd, 1'b0, 1'b1);
            if (ld) written++;
            budget++;
        end
        check("stream.budget", 32'(budget < 600), 32'(1));

        for (int i = 0; i < 5; i++)
            cycle("load5a", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
        cycle("clearWithWr", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        cycle("afterClearWr", 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        cycle("afterClearPop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++)
            cycle("load5b", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b1);
        cycle("resetWithWr", 1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
        cycle("afterRstWr", 1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        cycle("afterRstPop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Mixed random traffic biased toward writes so full/overflow paths recur.
        for (int i = 0; i < 300; i++)
            cycle("random", ($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 79) != 0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
